// File: rtl/dual_mode_buffer_if.sv
// Bus bundle for dual_mode_buffer: request side (mode, push, pop, write data)
// and status/read side (read data, flags, fill level, error pulses).
interface dual_mode_buffer_if #(
   parameter int BUFFER_SIZE = 8,
   parameter int DATA_WIDTH  = 8
);
   localparam int CW = $clog2(BUFFER_SIZE + 1);

   logic                  mode;
   logic                  push;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  pop;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  val;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [CW-1:0]         count;
   logic                  active_mode;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output mode, push, data_in, pop,
      input  data_out, val, full, empty, almost_full, almost_empty,
             count, active_mode, overflow, underflow
   );

   modport slave (
      input  mode, push, data_in, pop,
      output data_out, val, full, empty, almost_full, almost_empty,
             count, active_mode, overflow, underflow
   );
endinterface

// File: rtl/dual_mode_buffer.sv
// Run-time selectable FIFO/LIFO buffer with fill level, threshold flags and
// one-cycle overflow/underflow pulses. Mode changes only take effect while
// the buffer is empty and no push is requested.
module dual_mode_buffer #(
   parameter int BUFFER_SIZE = 8,
   parameter int DATA_WIDTH  = 8,
   parameter int AF_LEVEL    = BUFFER_SIZE - 1,
   parameter int AE_LEVEL    = 1
) (
   input logic               clock,
   input logic               reset,
   dual_mode_buffer_if.slave bus
);
   localparam int CW = $clog2(BUFFER_SIZE + 1);
   localparam int PW = $clog2(BUFFER_SIZE);

   typedef enum logic {
      MODE_FIFO = 1'b0,
      MODE_LIFO = 1'b1
   } mode_e;

   logic [DATA_WIDTH-1:0] mem [BUFFER_SIZE];
   logic [CW-1:0]         count_q;
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   mode_e                 mode_q;
   logic [DATA_WIDTH-1:0] data_out_q;
   logic                  val_q;
   logic                  overflow_q;
   logic                  underflow_q;

   logic                  full;
   logic                  empty;
   logic                  pop_acc;
   logic                  push_acc;
   logic                  load_mode;
   logic [PW-1:0]         rd_addr;
   logic [PW-1:0]         wr_addr;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(BUFFER_SIZE - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full      = (count_q == CW'(BUFFER_SIZE));
   assign empty     = (count_q == '0);
   assign pop_acc   = bus.pop && !empty;
   assign push_acc  = bus.push && (!full || pop_acc);
   assign load_mode = empty && !bus.push;

   // Storage addressing: ring pointers in FIFO mode, count-relative top in LIFO mode
   always_comb begin
      rd_addr = '0;
      wr_addr = '0;
      if (mode_q == MODE_LIFO) begin
         rd_addr = PW'(count_q - 1'b1);
         // A simultaneous pop frees the top slot, so the push replaces it
         wr_addr = pop_acc ? PW'(count_q - 1'b1) : PW'(count_q);
      end else begin
         rd_addr = rd_ptr;
         wr_addr = wr_ptr;
      end
   end

   // Storage array write; contents are not reset
   always_ff @(posedge clock) begin
      if (push_acc) begin
         mem[wr_addr] <= bus.data_in;
      end
   end

   // Control state: fill level, pointers, mode, read data and error pulses
   always_ff @(posedge clock) begin
      if (reset) begin
         count_q     <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         mode_q      <= MODE_FIFO;
         data_out_q  <= '0;
         val_q       <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         case ({push_acc, pop_acc})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase

         if (load_mode) begin
            mode_q <= mode_e'(bus.mode);
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else if (mode_q == MODE_FIFO) begin
            if (push_acc) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_acc)  rd_ptr <= ptr_inc(rd_ptr);
         end

         val_q <= pop_acc;
         if (pop_acc) begin
            data_out_q <= mem[rd_addr];
         end

         overflow_q  <= bus.push && full && !bus.pop;
         underflow_q <= bus.pop && empty;
      end
   end

   assign bus.data_out     = data_out_q;
   assign bus.val          = val_q;
   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
   assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
   assign bus.count        = count_q;
   assign bus.active_mode  = mode_q;
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;
endmodule
